spi_stream_sequencer: RTL and testbench
=======================================

// Module: spi_stream_sequencer
// PURPOSE
// Upstream driver for spi_controller_top: turns a valid/ready byte stream into controller transfers and returns
// received bytes as a valid/ready stream. Programs SPI mode (reg 3) and clock ratio (reg 4) over the register bus,
// buffers TX/RX in FIFOs, runs the request_tx/o_ready/o_rx_valid handshake per byte, and flags stalled transfers.
// PARAMETERS
// DEPTH          16    entries per FIFO; power of 2, >=2
// DEFAULT_MODE   0     SPI mode written after reset
// DEFAULT_RATIO  4     sclk divide ratio written after reset
// TIMEOUT        4096  cycles allowed per handshake phase before abort
// PORTS
// i_clk            in   1  system clock (100 MHz)
// i_rst_n          in   1  reset; synchronous, active-low
// i_cfg_mode       in   2  SPI mode for reprogramming
// i_cfg_ratio      in   8  clock ratio for reprogramming
// i_cfg_start      in   1  pulse: reprogram with i_cfg_*; honoured only in IDLE
// o_cfg_done       out  1  high once the last config write completes; low during any config sequence
// i_tx_data        in   8  byte to send
// i_tx_valid       in   1  TX stream valid
// o_tx_ready       out  1  TX FIFO not full
// o_rx_data        out  8  received byte (RX FIFO head)
// o_rx_valid       out  1  RX FIFO not empty
// i_rx_ready       in   1  consumer accepts o_rx_data
// o_busy           out  1  FSM not in IDLE, or TX FIFO non-empty
// o_err            out  1  one-cycle pulse on timeout abort
// o_ctl_ws_n       out  1  controller write strobe, active-low
// o_ctl_rs_n       out  1  controller read strobe; tied high (unused)
// o_ctl_addr       out  3  controller register address
// o_ctl_data       out  8  controller write data / TX byte
// o_ctl_request_tx out  1  transfer request
// i_ctl_data       in   8  controller received byte
// i_ctl_ready      in   1  controller idle
// i_ctl_rx_valid   in   1  controller received byte valid
// BEHAVIOUR
// - Reset (i_rst_n low at posedge): FIFOs empty; outputs 0 except o_ctl_ws_n=1, o_ctl_rs_n=1, o_tx_ready=1;
//   state CFG_WAIT; config values := DEFAULT_*. Reset mid-transfer drops all buffered and in-flight data.
// - CFG_WAIT: wait for i_ctl_ready=1 -> CFG_MODE. Config write = addr/data driven, ws_n low 2 cycles, then high 1 cycle.
// - CFG_MODE: addr=3, data={6'b0,mode} -> CFG_RATIO: addr=4, data=ratio -> IDLE; o_cfg_done=1; addr/data return to 0.
// - IDLE: priority i_cfg_start (latch i_cfg_*, o_cfg_done=0, -> CFG_WAIT) over transfer. Transfer starts when TX
//   non-empty, i_ctl_ready=1, and RX FIFO has >=1 free slot (reserve it; never overflow): pop TX,
//   o_ctl_data=byte, request_tx=1 -> REQ.
// - REQ: hold request_tx and data until i_ctl_ready falls; request_tx=0 the following cycle -> WAIT_RX.
// - WAIT_RX: on i_ctl_rx_valid rising edge capture i_ctl_data into RX FIFO same cycle -> IDLE.
// - Timeout: counter resets on entering REQ and WAIT_RX; reaching TIMEOUT -> request_tx=0, release reservation,
//   o_err pulse, -> IDLE; byte is lost.
// - FIFO push+pop same cycle when full/empty: TX full + pop allows push; RX empty + push does not bypass (1-cycle latency).
// - Pointers are log2(DEPTH)+1 bits, wrap naturally; count = wptr - rptr.
// - i_tx_valid with o_tx_ready=0: byte not accepted, upstream holds.
// STRUCTURE
// - spi_pkg: state enum (CFG_WAIT, CFG_MODE, CFG_RATIO, IDLE, REQ, WAIT_RX), REG_MODE=3, REG_RATIO=4.
// - Sub-module spi_stream_fifo (sync FIFO, WIDTH/DEPTH params, full/empty/count), instantiated for TX and RX.
// - Top: FSM, write-strobe sequencer, timeout counter, RX reservation counter.
// TESTING (bench wires to spi_controller_top, loops o_copi->i_cipo unless noted)
// - Reset release -> ws_n low 2 cycles with addr=3 data=0, then addr=4 data=4; o_cfg_done=1 after; no request_tx before.
// - Push 0xA5,0x3C,0xFF,0x00 in loopback -> o_rx_data yields same 4 bytes in order; o_busy falls after last.
// - Push DEPTH+4 bytes, i_rx_ready=0 -> o_tx_ready low at full, exactly DEPTH transfers, then stall; release -> rest drain.
// - i_cfg_start mode=3 ratio=16 while idle -> both writes seen; next 0x5A transfer uses mode 3, loops back 0x5A.
// - Hold i_ctl_ready=1, never rx_valid (stub controller) -> o_err pulse after TIMEOUT cycles, back to IDLE.
// - Assert i_rst_n=0 mid-byte with 3 bytes queued -> all outputs at reset values, FIFOs empty, config reruns.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI stream sequencer: FSM states and controller register map.
package spi_pkg;

  typedef enum logic [2:0] {
    CFG_WAIT,
    CFG_MODE,
    CFG_RATIO,
    IDLE,
    REQ,
    WAIT_RX
  } state_t;

  localparam logic [2:0] REG_MODE  = 3'd3;
  localparam logic [2:0] REG_RATIO = 3'd4;

endpackage

// File: rtl/spi_stream_fifo.sv
// Synchronous FIFO with extra pointer bit for full/empty; push accepted when full if a pop happens
// the same cycle; pop of an empty FIFO is ignored (no write-through bypass).
module spi_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wptr - r_rptr;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (o_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + CW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/spi_stream_sequencer.sv
// Drives spi_controller_top from a byte stream: programs mode/ratio, then one request_tx handshake per byte,
// returning received bytes through an RX FIFO whose slot is reserved before each transfer starts.
module spi_stream_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int DEFAULT_MODE  = 0,
  parameter int DEFAULT_RATIO = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_cfg_mode,
  input  logic [7:0] i_cfg_ratio,
  input  logic       i_cfg_start,
  output logic       o_cfg_done,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_busy,
  output logic       o_err,
  output logic       o_ctl_ws_n,
  output logic       o_ctl_rs_n,
  output logic [2:0] o_ctl_addr,
  output logic [7:0] o_ctl_data,
  output logic       o_ctl_request_tx,
  input  logic [7:0] i_ctl_data,
  input  logic       i_ctl_ready,
  input  logic       i_ctl_rx_valid
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        r_state, w_next;
  logic [1:0]    r_wcnt;
  logic [1:0]    r_mode;
  logic [7:0]    r_ratio;
  logic [7:0]    r_tx_byte;
  logic [TW-1:0] r_tmo;
  logic [CW-1:0] r_resv;
  logic          r_rxv_d, r_cfg_done, r_busy, r_err;

  logic          w_tx_pop, w_rx_push, w_start, w_abort, w_tmo_hit, w_rx_free;
  logic [7:0]    w_tx_rd_dat, w_rx_rd_dat;
  logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [CW-1:0] w_tx_count, w_rx_count;
  logic          w_unused;

  spi_stream_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_push(i_tx_valid && o_tx_ready), .i_data(i_tx_data), .i_pop(w_tx_pop),
    .o_data(w_tx_rd_dat), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  spi_stream_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_push(w_rx_push), .i_data(i_ctl_data), .i_pop(i_rx_ready),
    .o_data(w_rx_rd_dat), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  assign w_unused   = ^{w_tx_count, w_rx_full};
  assign o_tx_ready = !w_tx_full;
  assign o_rx_valid = !w_rx_empty;
  assign o_rx_data  = w_rx_empty ? 8'h00 : w_rx_rd_dat;
  assign o_cfg_done = r_cfg_done;
  assign o_busy     = r_busy;
  assign o_err      = r_err;
  assign o_ctl_rs_n = 1'b1;
  // In-flight bytes count against RX space so a completed transfer always has a slot.
  assign w_rx_free  = (w_rx_count + r_resv) < CW'(DEPTH);
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));

  always_comb begin
    w_next           = r_state;
    o_ctl_ws_n       = 1'b1;
    o_ctl_addr       = 3'd0;
    o_ctl_data       = 8'h00;
    o_ctl_request_tx = 1'b0;
    w_tx_pop         = 1'b0;
    w_rx_push        = 1'b0;
    w_start          = 1'b0;
    w_abort          = 1'b0;
    case (r_state)
      CFG_WAIT: if (i_ctl_ready) w_next = CFG_MODE;
      CFG_MODE: begin
        o_ctl_addr = REG_MODE;
        o_ctl_data = {6'b0, r_mode};
        o_ctl_ws_n = (r_wcnt == 2'd2);
        if (r_wcnt == 2'd2) w_next = CFG_RATIO;
      end
      CFG_RATIO: begin
        o_ctl_addr = REG_RATIO;
        o_ctl_data = r_ratio;
        o_ctl_ws_n = (r_wcnt == 2'd2);
        if (r_wcnt == 2'd2) w_next = IDLE;
      end
      IDLE: begin
        if (i_cfg_start) begin
          w_next = CFG_WAIT;
        end else if (!w_tx_empty && i_ctl_ready && w_rx_free) begin
          w_tx_pop = 1'b1;
          w_start  = 1'b1;
          w_next   = REQ;
        end
      end
      REQ: begin
        o_ctl_request_tx = 1'b1;
        o_ctl_data       = r_tx_byte;
        if (w_tmo_hit) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (!i_ctl_ready) begin
          w_next = WAIT_RX;
        end
      end
      WAIT_RX: begin
        o_ctl_data = r_tx_byte;
        if (i_ctl_rx_valid && !r_rxv_d) begin
          w_rx_push = 1'b1;
          w_next    = IDLE;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = CFG_WAIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= CFG_WAIT;
      r_wcnt     <= 2'd0;
      r_mode     <= 2'(DEFAULT_MODE);
      r_ratio    <= 8'(DEFAULT_RATIO);
      r_tx_byte  <= 8'h00;
      r_tmo      <= '0;
      r_resv     <= '0;
      r_rxv_d    <= 1'b0;
      r_cfg_done <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rxv_d <= i_ctl_rx_valid;
      r_err   <= w_abort;
      r_busy  <= (r_state != IDLE) || !w_tx_empty;
      if ((r_state == CFG_MODE || r_state == CFG_RATIO) && r_wcnt != 2'd2) r_wcnt <= r_wcnt + 2'd1;
      else r_wcnt <= 2'd0;
      if (r_state == IDLE && i_cfg_start) begin
        r_mode     <= i_cfg_mode;
        r_ratio    <= i_cfg_ratio;
        r_cfg_done <= 1'b0;
      end
      if (r_state == CFG_RATIO && r_wcnt == 2'd2) r_cfg_done <= 1'b1;
      if (w_start) r_tx_byte <= w_tx_rd_dat;
      // Each handshake phase gets its own timeout budget.
      if (w_next != r_state) r_tmo <= '0;
      else if (r_state == REQ || r_state == WAIT_RX) r_tmo <= r_tmo + TW'(1);
      if (w_start) r_resv <= r_resv + CW'(1);
      else if (w_rx_push || w_abort) r_resv <= r_resv - CW'(1);
    end
  end

endmodule

// File: tb/tb_spi_stream_sequencer.sv
// Scoreboard bench: behavioural controller model, expected RX bytes and config writes queued at stimulus time.
module tb_spi_stream_sequencer;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_ratio;
  logic       cfg_start;
  logic       cfg_done;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       err;
  logic       ws_n, rs_n, req;
  logic [2:0] addr;
  logic [7:0] ctl_wdata;
  logic [7:0] ctl_rdata;
  logic       ctl_ready;
  logic       ctl_rx_valid;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [10:0] cfg_q[$];

  bit         stub = 0, pause = 0;
  int         m_busy = 0;
  logic [7:0] m_byte;
  logic [1:0] m_mode = 2'd0;
  logic [7:0] m_ratio = 8'd4;
  logic [1:0] xfer_mode = 2'd0;
  int         xfers = 0;
  bit         req_before_done = 0;

  spi_stream_sequencer #(.DEPTH(DEPTH), .DEFAULT_MODE(0), .DEFAULT_RATIO(4), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_mode(cfg_mode), .i_cfg_ratio(cfg_ratio), .i_cfg_start(cfg_start), .o_cfg_done(cfg_done),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .o_busy(busy), .o_err(err),
    .o_ctl_ws_n(ws_n), .o_ctl_rs_n(rs_n), .o_ctl_addr(addr), .o_ctl_data(ctl_wdata),
    .o_ctl_request_tx(req), .i_ctl_data(ctl_rdata), .i_ctl_ready(ctl_ready), .i_ctl_rx_valid(ctl_rx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Controller model: registers on ws_n low, loopback transfer taking ratio+3 cycles.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      ctl_ready = 1'b1; ctl_rx_valid = 1'b0; ctl_rdata = 8'h00; m_busy = 0;
    end else begin
      ctl_rx_valid = 1'b0;
      if (!ws_n) begin
        if (addr == 3'd3) m_mode = ctl_wdata[1:0];
        if (addr == 3'd4) m_ratio = ctl_wdata;
      end
      if (stub) begin
        ctl_ready = 1'b1;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          ctl_rx_valid = 1'b1; ctl_rdata = m_byte; ctl_ready = 1'b1;
        end
      end else if (pause) begin
        ctl_ready = 1'b0;
      end else begin
        ctl_ready = 1'b1;
        if (req) begin
          m_byte = ctl_wdata; m_busy = int'(m_ratio) + 3; ctl_ready = 1'b0;
          xfers++; xfer_mode = m_mode;
        end
      end
    end
  end

  // RX monitor
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) chk("rx_unexpected", {56'h0, rx_data}, 64'hDEAD);
      else chk("rx_byte", {56'h0, rx_data}, {56'h0, exp_q.pop_front()});
    end
  end

  // Config-write monitor: each write must be a 2-cycle ws_n low pulse with stable addr/data.
  int         ws_run = 0;
  bit         ws_glitch = 0;
  logic [2:0] cap_addr;
  logic [7:0] cap_data;
  always @(negedge clk) begin
    if (req && !cfg_done) req_before_done = 1;
    if (!rst_n) begin
      ws_run = 0; ws_glitch = 0;
    end else if (!ws_n) begin
      if (ws_run == 0) begin cap_addr = addr; cap_data = ctl_wdata; end
      else if (addr != cap_addr || ctl_wdata != cap_data) ws_glitch = 1;
      ws_run++;
    end else if (ws_run > 0) begin
      if (cfg_q.size() == 0) chk("cfg_unexpected", {53'h0, cap_addr, cap_data}, 64'hDEAD);
      else chk("cfg_write", {ws_run[7:0], 7'h0, ws_glitch, 37'h0, cap_addr, cap_data},
               {8'd2, 8'h0, 37'h0, cfg_q.pop_front()});
      ws_run = 0; ws_glitch = 0;
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_rx);
    bit ok = 0;
    @(posedge clk); #2;
    tx_valid = 1'b1; tx_data = b;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    @(posedge clk); #2;
    tx_valid = 1'b0;
    if (!ok) chk("push_timeout", 64'h0, 64'h1);
    else if (expect_rx) exp_q.push_back(b);
  endtask

  task automatic wait_exp_empty(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_sig(input string name, input int which, input logic val, input int budget);
    logic cur;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cur = (which == 0) ? cfg_done : (which == 1) ? busy : req;
      if (cur == val) break;
    end
    chk(name, {63'h0, cur}, {63'h0, val});
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {ws_n, rs_n, tx_ready, busy, err, cfg_done, req, rx_valid, 5'h0, addr, ctl_wdata, rx_data},
        {1'b1, 1'b1, 1'b1, 5'b0, 5'h0, 3'd0, 8'h00, 8'h00});
  endtask

  int n, x0;

  initial begin
    rst_n = 0; cfg_mode = 0; cfg_ratio = 0; cfg_start = 0;
    tx_data = 0; tx_valid = 0; rx_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_outputs");

    // Default config after reset
    cfg_q.push_back({3'd3, 8'h00});
    cfg_q.push_back({3'd4, 8'h04});
    @(posedge clk); #2; rst_n = 1;
    wait_sig("cfg_done_after_reset", 0, 1'b1, 200);
    chk("cfg_writes_seen", cfg_q.size(), 0);
    chk("no_req_before_cfg_done", {63'h0, req_before_done}, 64'h0);
    chk("model_ratio_default", {56'h0, m_ratio}, 64'h4);

    // Loopback of four bytes
    push_byte(8'hA5, 1); push_byte(8'h3C, 1); push_byte(8'hFF, 1); push_byte(8'h00, 1);
    wait_exp_empty("loopback_drain", 500);
    wait_sig("busy_falls", 1, 1'b0, 100);

    // Fill TX while the controller is held off, then let RX fill and stall
    rx_ready = 0; pause = 1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h40 + 8'(i), 1);
    @(negedge clk);
    chk("tx_ready_low_when_full", {63'h0, tx_ready}, 64'h0);
    x0 = xfers;
    pause = 0;
    for (int i = DEPTH; i < DEPTH + 4; i++) push_byte(8'h40 + 8'(i), 1);
    for (int i = 0; i < 1000 && xfers - x0 < DEPTH; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    chk("stall_after_depth_xfers", xfers - x0, DEPTH);
    chk("busy_while_stalled", {63'h0, busy}, 64'h1);
    @(posedge clk); #2; rx_ready = 1;
    wait_exp_empty("stall_release_drain", 1000);
    wait_sig("busy_falls_after_drain", 1, 1'b0, 100);

    // Reprogram mode 3, ratio 16
    cfg_q.push_back({3'd3, 8'h03});
    cfg_q.push_back({3'd4, 8'h10});
    @(posedge clk); #2; cfg_mode = 2'd3; cfg_ratio = 8'd16; cfg_start = 1;
    @(posedge clk); #2; cfg_start = 0;
    @(negedge clk);
    chk("cfg_done_low_during_cfg", {63'h0, cfg_done}, 64'h0);
    wait_sig("cfg_done_after_reprogram", 0, 1'b1, 200);
    chk("reprogram_writes_seen", cfg_q.size(), 0);
    push_byte(8'h5A, 1);
    wait_exp_empty("mode3_loopback", 500);
    chk("xfer_used_mode3", {62'h0, xfer_mode}, 64'h3);

    // Timeout abort with a controller that never answers
    stub = 1;
    push_byte(8'h77, 0);
    wait_sig("req_seen_stub", 2, 1'b1, 100);
    n = 0;
    while (req && n < TIMEOUT + 20) begin n++; @(negedge clk); end
    chk("req_cycles_before_abort", n, TIMEOUT);
    chk("err_pulse_high", {63'h0, err}, 64'h1);
    @(negedge clk);
    chk("err_pulse_one_cycle", {63'h0, err}, 64'h0);
    @(posedge clk); #2; stub = 0;
    push_byte(8'h11, 1);
    wait_exp_empty("after_timeout_loopback", 500);

    // Reset in the middle of a byte with more queued
    push_byte(8'h21, 1); push_byte(8'h22, 1); push_byte(8'h23, 1);
    for (int i = 0; i < 200 && m_busy == 0; i++) @(negedge clk);
    chk("transfer_in_flight", {63'h0, (m_busy > 0)}, 64'h1);
    @(posedge clk); #2; rst_n = 0;
    exp_q.delete();
    x0 = xfers;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midbyte_reset_outputs");
    cfg_q.push_back({3'd3, 8'h00});
    cfg_q.push_back({3'd4, 8'h04});
    @(posedge clk); #2; rst_n = 1;
    wait_sig("cfg_done_after_midreset", 0, 1'b1, 200);
    chk("midreset_cfg_writes_seen", cfg_q.size(), 0);
    repeat (100) @(negedge clk);
    chk("fifos_flushed", {62'h0, rx_valid, busy}, 64'h0);
    chk("no_xfer_after_reset", xfers - x0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
